// File: rtl/handshake_gen_if.sv
// Control and AXI-stream bundle for handshake_gen.
// HANDSHAKE_GEN_TLAST_EN adds m_axis_tlast to the stream side.
interface handshake_gen_if #(
   parameter int unsigned DATA_W = 128
);
   logic              start;
   logic [31:0]       cnt_limit;
   logic [7:0]        gap_cycles;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              busy;
   logic              done;
   logic [31:0]       data_cnt;
   logic [31:0]       cycle_cnt;
`ifdef HANDSHAKE_GEN_TLAST_EN
   logic              m_axis_tlast;

   modport master (
      input  start, cnt_limit, gap_cycles, m_axis_tready,
      output m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done, data_cnt, cycle_cnt
   );

   modport slave (
      output start, cnt_limit, gap_cycles, m_axis_tready,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done, data_cnt, cycle_cnt
   );
`else
   modport master (
      input  start, cnt_limit, gap_cycles, m_axis_tready,
      output m_axis_tvalid, m_axis_tdata, busy, done, data_cnt, cycle_cnt
   );

   modport slave (
      output start, cnt_limit, gap_cycles, m_axis_tready,
      input  m_axis_tvalid, m_axis_tdata, busy, done, data_cnt, cycle_cnt
   );
`endif
endinterface

// File: rtl/handshake_gen.sv
// AXI-stream burst source: cnt_limit patterned beats per start, optional idle gap between beats.
// Define HANDSHAKE_GEN_TLAST_EN to drive m_axis_tlast on the final beat.
module handshake_gen #(
   parameter int unsigned DATA_W = 128,
   parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
   input  logic            clk,
   input  logic            reset,
   handshake_gen_if.master bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StGap  = 2'd2,
      StDone = 2'd3
   } state_e;

   state_e      r_state_q, r_state_d;
   logic [31:0] r_limit_q, r_limit_d;
   logic [7:0]  r_gap_q, r_gap_d;
   logic [7:0]  r_gap_cnt_q, r_gap_cnt_d;
   logic [31:0] r_data_cnt_q, r_data_cnt_d;
   logic [31:0] r_cycle_cnt_q, r_cycle_cnt_d;

   logic              w_run;
   logic              w_hs;
   logic [31:0]       w_idx;
   logic [DATA_W-1:0] w_tdata;

   // The beat index is the accepted-beat count, so no separate idx register is kept.
   assign w_idx = r_data_cnt_q;
   assign w_run = (r_state_q == StRun);
   assign w_hs  = w_run & bus.m_axis_tready;

   always_comb begin
      w_tdata = '0;
      if (w_run) begin
         w_tdata[127:0] = {SEED, ~w_idx, w_idx, w_idx};
      end
   end

   always_comb begin
      r_state_d     = r_state_q;
      r_limit_d     = r_limit_q;
      r_gap_d       = r_gap_q;
      r_gap_cnt_d   = r_gap_cnt_q;
      r_data_cnt_d  = r_data_cnt_q;
      r_cycle_cnt_d = r_cycle_cnt_q;
      unique case (r_state_q)
         StIdle: begin
            if (bus.start) begin
               r_limit_d     = bus.cnt_limit;
               r_gap_d       = bus.gap_cycles;
               r_data_cnt_d  = '0;
               r_cycle_cnt_d = '0;
               r_state_d     = (bus.cnt_limit == 32'd0) ? StDone : StRun;
            end
         end
         StRun: begin
            r_cycle_cnt_d = r_cycle_cnt_q + 32'd1;
            if (w_hs) begin
               r_data_cnt_d = r_data_cnt_q + 32'd1;
               if (r_data_cnt_d == r_limit_q) begin
                  r_state_d = StDone;
               end else if (r_gap_q != 8'd0) begin
                  r_gap_cnt_d = r_gap_q;
                  r_state_d   = StGap;
               end
            end
         end
         StGap: begin
            r_cycle_cnt_d = r_cycle_cnt_q + 32'd1;
            r_gap_cnt_d   = r_gap_cnt_q - 8'd1;
            if (r_gap_cnt_q == 8'd1) begin
               r_state_d = StRun;
            end
         end
         StDone: begin
            r_state_d = StIdle;
         end
         default: begin
            r_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q     <= StIdle;
         r_limit_q     <= '0;
         r_gap_q       <= '0;
         r_gap_cnt_q   <= '0;
         r_data_cnt_q  <= '0;
         r_cycle_cnt_q <= '0;
      end else begin
         r_state_q     <= r_state_d;
         r_limit_q     <= r_limit_d;
         r_gap_q       <= r_gap_d;
         r_gap_cnt_q   <= r_gap_cnt_d;
         r_data_cnt_q  <= r_data_cnt_d;
         r_cycle_cnt_q <= r_cycle_cnt_d;
      end
   end

   assign bus.m_axis_tvalid = w_run;
   assign bus.m_axis_tdata  = w_tdata;
   assign bus.busy          = (r_state_q == StRun) || (r_state_q == StGap);
   assign bus.done          = (r_state_q == StDone);
   assign bus.data_cnt      = r_data_cnt_q;
   assign bus.cycle_cnt     = r_cycle_cnt_q;

`ifdef HANDSHAKE_GEN_TLAST_EN
   assign bus.m_axis_tlast = w_run && (w_idx == (r_limit_q - 32'd1));
`endif

endmodule
